// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op codes, FSM states, widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hilo_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULU  = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    // Two's complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_mac_ctrl_core.sv
// Radix-2 shift-add unsigned multiplier datapath: multiplicand, 2W accumulator, iteration counter.
// Latency: one iteration per step_i; ITER steps after load_i the accumulator holds the product.
// Backpressure: none; the controller sequences load_i/step_i and watches last_o.
module seq_mult_core
    import hilo_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               last_o
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     upper_sum;

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(ITER - 1));

    // Next state: load seeds the multiplier in the low half; each step adds and shifts right.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        if (load_i) begin
            mcand_d = mcand_i;
            acc_d   = {{WIDTH{1'b0}}, mplier_i};
            cnt_d   = '0;
        end else if (step_i) begin
            // The carry out of the add becomes the new MSB after the shift.
            acc_d = {upper_sum, acc_q[WIDTH-1:1]};
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hilo_mac_ctrl.sv
// HI/LO owner and multiply/accumulate sequencer (MUL, MULU, MADD, MADDU, MTHI, MTLO).
// Latency: multiply class 33 cycles busy, HI/LO at accept+33, done the cycle after; MTHI/MTLO write at accept, done next cycle.
// Backpressure: start_i is taken only in IDLE and dropped otherwise; flush_i aborts with no write and no done.
module hilo_mac_ctrl
    import hilo_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_t             state_q, state_d;
    logic               neg_q, neg_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               load, step, last;
    logic               is_signed;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc, prod, sum;

    // Signed ops feed magnitudes to the unsigned core; the sign is reapplied in WB.
    assign is_signed = (op_i == OP_MUL) || (op_i == OP_MADD);
    assign mcand     = is_signed ? mag(a_i) : a_i;
    assign mplier    = is_signed ? mag(b_i) : b_i;
    assign prod      = neg_q ? ('0 - acc) : acc;
    assign sum       = {hi_q, lo_q} + prod;

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

    seq_mult_core u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (mcand),
        .mplier_i (mplier),
        .acc_o    (acc),
        .last_o   (last)
    );

    // FSM next state, HI/LO/result updates and the done pulse.
    always_comb begin
        state_d  = state_q;
        neg_d    = neg_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // flush beats a same-cycle start.
                if (start_i && !flush_i) begin
                    case (op_i)
                        OP_MUL, OP_MULU, OP_MADD, OP_MADDU: begin
                            load    = 1'b1;
                            op_d    = op_i;
                            neg_d   = is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            state_d = MUL;
                        end
                        OP_MTHI: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            MUL: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) state_d = WB;
                end
            end
            WB: begin
                if (!flush_i) begin
                    if ((op_q == OP_MUL) || (op_q == OP_MULU)) begin
                        {hi_d, lo_d} = prod;
                        result_d     = prod[WIDTH-1:0];
                    end else begin
                        {hi_d, lo_d} = sum;
                    end
                    done_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Architectural and control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule
